// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith/shift ops plus iterative unsigned MUL/DIV.
// Results and flags are registered and change only in the cycle that done pulses.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SHRA = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8, OP_ROR = 4'd9, OP_NEG = 4'd10, OP_NOT = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_DIV = 4'd13;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic ovf_q, ovf_d, dbz_q, dbz_d, ill_q, ill_d;

    logic [SHW-1:0]   sh_amt, rol_amt;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic [WIDTH-1:0] sub_x, sub_y;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_carry, sc_ovf, sc_dbz, sc_ill;

    always_comb begin
        sh_amt   = operand_B[SHW-1:0];
        rol_amt  = '0 - sh_amt;
        sub_x    = (opcode == OP_NEG) ? '0 : operand_A;
        sub_y    = (opcode == OP_NEG) ? operand_A : operand_B;
        add_sum  = {1'b0, operand_A} + {1'b0, operand_B};
        sub_diff = {1'b0, sub_x} - {1'b0, sub_y};
        sc_lo    = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dbz   = 1'b0;
        sc_ill   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_lo    = add_sum[WIDTH-1:0];
                sc_carry = add_sum[WIDTH];
                sc_ovf   = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != operand_A[WIDTH-1]);
            end
            // carry on subtract means "no borrow"
            OP_SUB, OP_NEG: begin
                sc_lo    = sub_diff[WIDTH-1:0];
                sc_carry = ~sub_diff[WIDTH];
                sc_ovf   = (sub_x[WIDTH-1] != sub_y[WIDTH-1]) &&
                           (sub_diff[WIDTH-1] != sub_x[WIDTH-1]);
            end
            OP_AND:  sc_lo = operand_A & operand_B;
            OP_OR:   sc_lo = operand_A | operand_B;
            OP_XOR:  sc_lo = operand_A ^ operand_B;
            OP_SHL:  sc_lo = operand_A << sh_amt;
            OP_SHR:  sc_lo = operand_A >> sh_amt;
            OP_SHRA: sc_lo = $unsigned($signed(operand_A) >>> sh_amt);
            OP_ROL:  sc_lo = WIDTH'({operand_A, operand_A} >> rol_amt);
            OP_ROR:  sc_lo = WIDTH'({operand_A, operand_A} >> sh_amt);
            OP_NOT:  sc_lo = ~operand_A;
            OP_DIV: begin
                sc_lo  = '1;
                sc_hi  = operand_A;
                sc_dbz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!is_div_q)
            step = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!div_trial[WIDTH])
            step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    logic             load;
    logic [WIDTH-1:0] fin_lo, fin_hi;
    logic             fin_carry, fin_ovf, fin_dbz, fin_ill;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        load      = 1'b0;
        fin_lo    = '0;
        fin_hi    = '0;
        fin_carry = 1'b0;
        fin_ovf   = 1'b0;
        fin_dbz   = 1'b0;
        fin_ill   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = 1'b0;
                        opnd_d   = operand_A;
                        acc_d    = {{WIDTH{1'b0}}, operand_B};
                    end else if (opcode == OP_DIV && operand_B != '0) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = 1'b1;
                        opnd_d   = operand_B;
                        acc_d    = {{WIDTH{1'b0}}, operand_A};
                    end else begin
                        state_d   = FIN;
                        load      = 1'b1;
                        fin_lo    = sc_lo;
                        fin_hi    = sc_hi;
                        fin_carry = sc_carry;
                        fin_ovf   = sc_ovf;
                        fin_dbz   = sc_dbz;
                        fin_ill   = sc_ill;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = FIN;
                    load    = 1'b1;
                    fin_lo  = step[WIDTH-1:0];
                    fin_hi  = step[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase

        lo_d    = lo_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        ill_d   = ill_q;
        if (load) begin
            lo_d    = fin_lo;
            hi_d    = fin_hi;
            zero_d  = (fin_lo == '0) && (fin_hi == '0);
            neg_d   = fin_lo[WIDTH-1];
            carry_d = fin_carry;
            ovf_d   = fin_ovf;
            dbz_d   = fin_dbz;
            ill_d   = fin_ill;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign result_lo   = lo_q;
    assign result_hi   = hi_q;
    assign zero        = zero_q;
    assign negative    = neg_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected responses, a monitor checks each done.
// A second 8-bit instance covers the narrow-width multiply.
module tb_alu_seq;
    localparam int W = 32;
    localparam logic [5:0] F_Z = 6'b100000, F_N = 6'b010000, F_C = 6'b001000;
    localparam logic [5:0] F_V = 6'b000100, F_D = 6'b000010, F_I = 6'b000001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   opcode = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, zero, negative, carry, overflow, div_by_zero, illegal_op;
    logic [W-1:0] result_lo, result_hi;

    logic       start8 = 1'b0;
    logic [3:0] opcode8 = 4'd12;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, zero8, neg8, carry8, ovf8, dbz8, ill8;
    logic [7:0] lo8, hi8;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .operand_A(a), .operand_B(b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .opcode(opcode8),
        .operand_A(a8), .operand_B(b8), .busy(busy8), .done(done8),
        .result_lo(lo8), .result_hi(hi8), .zero(zero8),
        .negative(neg8), .carry(carry8), .overflow(ovf8),
        .div_by_zero(dbz8), .illegal_op(ill8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           id;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [5:0]   fl;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("v%0d_result", mon_e.id), {result_hi, result_lo}, {mon_e.hi, mon_e.lo});
                chk($sformatf("v%0d_flags", mon_e.id),
                    {58'd0, zero, negative, carry, overflow, div_by_zero, illegal_op},
                    {58'd0, mon_e.fl});
                chk($sformatf("v%0d_latency", mon_e.id), 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
    end

    task automatic push_exp(input int id, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                            input logic [5:0] efl, input int elat);
        exp_t e;
        e.id = id; e.lo = elo; e.hi = ehi; e.fl = efl; e.lat = elat; e.t0 = cyc;
        sb.push_back(e);
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input bit push, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input logic [5:0] efl, input int elat);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'd1, 64'd0);
        opcode = op; a = av; b = bv; start = 1'b1;
        if (push) push_exp(id, elo, ehi, efl, elat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] sh_b;
        int t8;
        bit seen8;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {56'd0, busy, done, zero, negative, carry, overflow, div_by_zero, illegal_op}, 64'd0);
        chk("rst_result", {result_hi, result_lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 4'd0, 32'hFFFFFFFF, 32'd1, 1, 32'h0, 32'h0, F_Z | F_C, 1);
        issue(2, 4'd0, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 32'h0, F_N | F_V, 1);
        issue(3, 4'd1, 32'd3, 32'd5, 1, 32'hFFFFFFFE, 32'h0, F_N, 1);
        issue(4, 4'd1, 32'd5, 32'd3, 1, 32'd2, 32'h0, F_C, 1);
        for (int k = 0; k < 2; k++) begin
            sh_b = (k == 0) ? 32'd4 : 32'd36;
            issue(10 + 4*k, 4'd7, 32'h80000001, sh_b, 1, 32'hF8000000, 32'h0, F_N, 1);
            issue(11 + 4*k, 4'd6, 32'h80000001, sh_b, 1, 32'h08000000, 32'h0, 6'd0, 1);
            issue(12 + 4*k, 4'd8, 32'h80000001, sh_b, 1, 32'h00000018, 32'h0, 6'd0, 1);
            issue(13 + 4*k, 4'd9, 32'h80000001, sh_b, 1, 32'h18000000, 32'h0, 6'd0, 1);
        end
        issue(20, 4'd10, 32'h0, 32'h1234, 1, 32'h0, 32'h0, F_Z | F_C, 1);
        issue(21, 4'd10, 32'h80000000, 32'h0, 1, 32'h80000000, 32'h0, F_N | F_V, 1);
        issue(22, 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 32'h0, F_N, 1);
        issue(23, 4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hFFF0FFF0, 32'h0, F_N, 1);
        issue(24, 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0FF00FF0, 32'h0, 6'd0, 1);
        issue(25, 4'd5, 32'h1, 32'd31, 1, 32'h80000000, 32'h0, F_N, 1);
        issue(26, 4'd11, 32'h0000FFFF, 32'h0, 1, 32'hFFFF0000, 32'h0, F_N, 1);

        // multiply with a stray start mid-run and a hold check on the outputs
        issue(30, 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, 32'hFFFFFFFE, 6'd0, 33);
        repeat (4) @(negedge clk);
        chk("mul_hold", {31'd0, busy, result_lo}, {31'd0, 1'b1, 32'hFFFF0000});
        opcode = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        issue(31, 4'd13, 32'd100, 32'd7, 1, 32'd14, 32'd2, 6'd0, 33);
        issue(32, 4'd13, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, F_N | F_D, 1);
        issue(33, 4'd2, 32'hF, 32'h3, 1, 32'd3, 32'h0, 6'd0, 1);
        drain();

        // reset mid-multiply, with a start presented alongside the reset
        issue(0, 4'd12, 32'd7, 32'd9, 0, 32'h0, 32'h0, 6'd0, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1; opcode = 4'd0; a = 32'd1; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        chk("abort_ctrl", {56'd0, busy, done, zero, negative, carry, overflow, div_by_zero, illegal_op}, 64'd0);
        chk("abort_result", {result_hi, result_lo}, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", {63'd0, busy}, 64'd0);

        issue(40, 4'd14, 32'd5, 32'd5, 1, 32'h0, 32'h0, F_Z | F_I, 1);
        issue(41, 4'd15, 32'hFFFFFFFF, 32'd1, 1, 32'h0, 32'h0, F_Z | F_I, 1);

        // start held high is re-accepted at the first idle edge
        drain();
        opcode = 4'd0; a = 32'd1; b = 32'd2; start = 1'b1;
        push_exp(50, 32'd3, 32'h0, 6'd0, 1);
        @(negedge clk);
        @(negedge clk);
        push_exp(51, 32'd3, 32'h0, 6'd0, 1);
        @(negedge clk);
        start = 1'b0;
        drain();

        // narrow instance
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        t8 = cyc;
        @(negedge clk);
        start8 = 1'b0;
        seen8 = 1'b0;
        for (int n = 0; n < 30 && !seen8; n++) begin
            if (done8 === 1'b1) begin
                seen8 = 1'b1;
                chk("w8_mul_latency", 64'(cyc - t8), 64'd9);
                chk("w8_mul_result", {48'd0, hi8, lo8}, 64'h0000_0000_0000_FE01);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen8) chk("w8_mul_done_timeout", 64'd0, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's combinational datapath ALU. Single-cycle logic, arithmetic and shift operations sit beside multi-cycle unsigned multiply and divide, under a start/busy/done handshake. Outputs are a double-width result (hi/lo) and status flags. The block sits between the register-file read ports and the result/HI/LO write-back path.

## Interface
- WIDTH, 32: operand and result_lo/result_hi width; must be a power of two, at least 8.
- SHW, $clog2(WIDTH): shift-amount width, derived; not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  request; sampled only when busy=0.
- opcode  in  4  operation select; latched with start.
- operand_A  in  WIDTH  first operand; latched with start.
- operand_B  in  WIDTH  second operand or shift amount (low SHW bits); latched with start.
- busy  out  1  high while an operation is in flight; start is ignored while high.
- done  out  1  one-cycle pulse; result_lo, result_hi and the flags are valid from this cycle.
- result_lo  out  WIDTH  result, product low half, or quotient.
- result_hi  out  WIDTH  product high half, or remainder; 0 for single-cycle ops.
- zero, negative, carry, overflow  out  1 each  status flags.
- div_by_zero, illegal_op  out  1 each  error flags.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical), 7 SHRA (arithmetic), 8 ROL, 9 ROR; shift amount is operand_B[SHW-1:0].
  - 10 NEG (0 - A), 11 NOT (~A).
  - 12 MUL: unsigned A*B, 2*WIDTH bits.
  - 13 DIV: unsigned A/B, quotient plus remainder.
  - 14, 15: illegal.
- Arithmetic is modulo 2^WIDTH.
- carry:
  - ADD: carry-out.
  - SUB/NEG: 1 when no borrow (A >= B unsigned; NEG: A == 0).
  - All other ops: 0.
- overflow: two's-complement overflow for ADD/SUB/NEG; 0 otherwise.
- zero: set when result_lo == 0 and result_hi == 0. negative: set from the MSB of result_lo.
- MUL: shift-add, one bit of B per cycle, for WIDTH iterations.
- DIV: restoring division, one quotient bit per cycle, for WIDTH iterations.
- DIV with B == 0:
  - No iteration.
  - Quotient = all ones, remainder = A, div_by_zero = 1.
  - Done follows the single-cycle timing.
- Illegal opcode: result_lo = result_hi = 0, illegal_op = 1, zero = 1, single-cycle timing.
- Error flags are cleared on every done that does not set them.
- FSM states: IDLE, RUN, FIN.
  - IDLE & start & single-cycle op (including DIV by zero and illegal): go to FIN, compute and register the result.
  - IDLE & start & MUL/DIV: go to RUN, load the operands, set the iteration counter to 0.
  - RUN: one iteration per cycle; after iteration WIDTH-1 go to FIN.
  - FIN: assert done for one cycle, go to IDLE.
- busy = (state != IDLE).
- Outputs hold their last value until the next done; they do not change during RUN.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE; busy, done and all flags = 0; result_lo = result_hi = 0; counter = 0.
  - A reset mid-RUN aborts the operation; no done is produced.
- Start is accepted at edge T.
  - Single-cycle ops: busy = 1 and done = 1 in cycle T+1, busy = 0 in cycle T+2.
  - MUL/DIV: busy = 1 from T+1 to T+WIDTH+1; done pulses in cycle T+WIDTH+1; busy = 0 in cycle T+WIDTH+2.
  - Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV.
- Throughput: the earliest next start is accepted in the first cycle with busy = 0. A start held high continuously is re-accepted at every IDLE edge.
- Operand or opcode changes after acceptance have no effect on the in-flight operation.
- A start asserted in the same cycle as rst_n = 0 is discarded.

## Test plan
- Reset, then ADD with A = 0xFFFFFFFF, B = 1 -> done after 1 cycle; result_lo = 0, zero = 1, carry = 1, overflow = 0.
- ADD with A = 0x7FFFFFFF, B = 1 -> result_lo = 0x80000000, overflow = 1, negative = 1. Then SUB with A = 3, B = 5 -> result_lo = 0xFFFFFFFE, carry = 0.
- Shifts with A = 0x80000001, B = 4:
  - SHRA -> 0xF8000000.
  - SHR -> 0x08000000.
  - ROL -> 0x00000018.
  - ROR -> 0x18000000.
  - B = 36 gives the same results (only the low 5 bits are used).
- MUL with A = 0xFFFFFFFF, B = 0xFFFFFFFF -> busy for 33 cycles, done in cycle T+33; result_hi = 0xFFFFFFFE, result_lo = 0x00000001. A start pulsed mid-RUN is ignored.
- DIV:
  - A = 100, B = 7 -> result_lo = 14, result_hi = 2 at T+33.
  - A = 5, B = 0 -> done at T+1; result_lo = 0xFFFFFFFF, result_hi = 5, div_by_zero = 1.
- Drop rst_n mid-MUL at cycle T+10 -> next cycle busy = 0, outputs 0, no done pulse. Then opcode 14 -> illegal_op = 1, result 0. Also run the bench with WIDTH = 8: MUL 0xFF*0xFF -> hi = 0xFE, lo = 0x01, done at T+9.
